// File: rtl/demux_stream_1ton_pkg.sv
// Shared steering-mode encodings and target decode for the 1-to-N stream demux.
package demux_pkg;

  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned MAX_SEL_W = 4;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_BCAST = 2'b01,
    MODE_RR    = 2'b10
  } mode_e;

  // Reserved mode 2'b11 decodes as addressed; an out-of-range select yields no target.
  function automatic logic [MAX_CH-1:0] target_vec(
    input logic [1:0]           mode,
    input logic [MAX_SEL_W-1:0] sel,
    input logic [MAX_SEL_W-1:0] rr,
    input int unsigned          n_ch
  );
    logic [MAX_CH-1:0] v;
    v = '0;
    case (mode)
      MODE_BCAST: for (int unsigned i = 0; i < MAX_CH; i++) v[i] = (i < n_ch);
      MODE_RR:    v[rr] = 1'b1;
      default:    if (32'(sel) < n_ch) v[sel] = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/demux_stream_1ton_if.sv
// Producer stream plus N consumer streams of the 1-to-N demux.
interface demux_stream_1ton_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
);
  logic [1:0]             mode;
  logic [DATA_W-1:0]      din;
  logic [SEL_W-1:0]       sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*DATA_W-1:0] dout;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;

  modport master (
    output mode, din, sel, in_valid, out_ready,
    input  in_ready, dout, out_valid
  );

  modport slave (
    input  mode, din, sel, in_valid, out_ready,
    output in_ready, dout, out_valid
  );
endinterface

// File: rtl/demux_stream_1ton_chan_reg.sv
// One-entry output buffer for a single demux channel; a load wins over a drain.
module demux_chan_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demux: addressed, broadcast and round-robin steering.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_stream_1ton_if.slave bus,
  output logic             err,
  output logic [SEL_W-1:0] rr_ptr
);

  logic [MAX_CH-1:0] tgt_full;
  logic [N_CH-1:0]   tgt;
  logic [N_CH-1:0]   can_take;
  logic [N_CH-1:0]   load;
  logic              oor;
  logic              accept;

  // An out-of-range addressed beat has an empty target set and is always accepted.
  always_comb begin
    tgt_full     = target_vec(bus.mode, MAX_SEL_W'(bus.sel), MAX_SEL_W'(rr_ptr), N_CH);
    tgt          = tgt_full[N_CH-1:0];
    can_take     = ~bus.out_valid | bus.out_ready;
    oor          = (bus.mode != MODE_BCAST) && (bus.mode != MODE_RR) &&
                   (32'(bus.sel) >= N_CH);
    bus.in_ready = oor || ((can_take | ~tgt) == '1);
    accept       = bus.in_valid && bus.in_ready;
    load         = accept ? tgt : '0;
  end

  if (N_CH < MAX_CH) begin : g_unused
    logic unused_tgt_hi;
    assign unused_tgt_hi = |tgt_full[MAX_CH-1:N_CH];
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    demux_chan_reg #(.DATA_W(DATA_W)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .din   (bus.din),
      .ready (bus.out_ready[i]),
      .valid (bus.out_valid[i]),
      .dout  (bus.dout[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept && oor;
      if (accept && (bus.mode == MODE_RR))
        rr_ptr <= (rr_ptr == SEL_W'(N_CH-1)) ? '0 : rr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton with a per-channel scoreboard on the 4-channel instance.
module tb_demux_stream_1ton;

  logic       clk;
  logic       rst_n;
  logic       err4, err3;
  logic [1:0] rr4, rr3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned ch;
    logic [7:0]  d;
  } sb_t;
  sb_t sb[$];

  demux_stream_1ton_if #(.DATA_W(8), .N_CH(4)) b4 ();
  demux_stream_1ton_if #(.DATA_W(8), .N_CH(3)) b3 ();

  demux_stream_1ton #(.DATA_W(8), .N_CH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .err(err4), .rr_ptr(rr4)
  );
  demux_stream_1ton #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .err(err3), .rr_ptr(rr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops every beat that drains at the coming edge and compares its data.
  task automatic tick();
    for (int unsigned c = 0; c < 4; c++) begin
      if (b4.out_valid[c] && b4.out_ready[c]) begin
        int idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].ch == c) idx = k;
        check("sb_found", 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          check("sb_data", 32'(b4.dout[c*8 +: 8]), 32'(sb[idx].d));
          sb.delete(idx);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] tgt_exp, input logic rdy_exp);
    sb_t e;
    b4.mode = m; b4.sel = s; b4.din = d; b4.in_valid = 1'b1;
    #1;
    check("in_ready", 32'(b4.in_ready), 32'(rdy_exp));
    if (rdy_exp) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (tgt_exp[c]) begin
          e.ch = c; e.d = d;
          sb.push_back(e);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b4.mode = 2'b00; b4.sel = '0; b4.din = '0; b4.in_valid = 1'b0; b4.out_ready = 4'b1111;
    b3.mode = 2'b00; b3.sel = '0; b3.din = '0; b3.in_valid = 1'b0; b3.out_ready = 3'b111;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(b4.out_valid), 32'h0);
    check("rst_dout", b4.dout, 32'h0);
    check("rst_err", 32'(err4), 32'h0);
    check("rst_rr", 32'(rr4), 32'h0);
    check("rst_in_ready", 32'(b4.in_ready), 32'h1);
    check("rst_out_valid3", 32'(b3.out_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // addressed sweep at full throughput
    for (int s = 0; s < 4; s++) begin
      beat(2'b00, 2'(s), 8'hA5, 4'(1 << s), 1'b1);
      tick();
      check("sweep_valid", 32'(b4.out_valid), 32'(1 << s));
      check("sweep_dout", 32'(b4.dout[s*8 +: 8]), 32'hA5);
    end
    b4.in_valid = 1'b0;
    tick();
    check("sweep_idle", 32'(b4.out_valid), 32'h0);

    // backpressure on channel 2
    b4.out_ready = 4'b1011;
    beat(2'b00, 2'd2, 8'h11, 4'b0100, 1'b1);
    tick();
    check("bp_valid1", 32'(b4.out_valid), 32'h4);
    beat(2'b00, 2'd2, 8'h22, 4'b0100, 1'b0);
    tick();
    check("bp_hold_valid", 32'(b4.out_valid), 32'h4);
    check("bp_hold_data", 32'(b4.dout[23:16]), 32'h11);
    b4.out_ready = 4'b1111;
    beat(2'b00, 2'd2, 8'h22, 4'b0100, 1'b1);
    tick();
    check("bp_reload_valid", 32'(b4.out_valid), 32'h4);
    check("bp_reload_data", 32'(b4.dout[23:16]), 32'h22);
    b4.in_valid = 1'b0;
    tick();
    check("bp_idle", 32'(b4.out_valid), 32'h0);

    // broadcast blocked by one full, stalled channel
    b4.out_ready = 4'b1011;
    beat(2'b00, 2'd2, 8'h77, 4'b0100, 1'b1);
    tick();
    beat(2'b01, 2'd0, 8'h3C, 4'b1111, 1'b0);
    tick();
    check("bc_no_partial", 32'(b4.out_valid), 32'h4);
    b4.out_ready = 4'b1111;
    beat(2'b01, 2'd0, 8'h3C, 4'b1111, 1'b1);
    tick();
    check("bc_valid", 32'(b4.out_valid), 32'hF);
    check("bc_dout", b4.dout, 32'h3C3C3C3C);
    b4.in_valid = 1'b0;
    tick();
    check("bc_idle", 32'(b4.out_valid), 32'h0);

    // round-robin wrap
    for (int k = 1; k <= 6; k++) begin
      beat(2'b10, 2'd0, 8'(k), 4'(1 << ((k-1) % 4)), 1'b1);
      tick();
      check("rr_valid", 32'(b4.out_valid), 32'(1 << ((k-1) % 4)));
    end
    check("rr_ptr_after6", 32'(rr4), 32'h2);
    b4.in_valid = 1'b0;
    tick();

    // stalled round-robin beat holds the pointer
    b4.out_ready = 4'b1011;
    beat(2'b00, 2'd2, 8'h55, 4'b0100, 1'b1);
    tick();
    beat(2'b10, 2'd0, 8'h66, 4'b0100, 1'b0);
    tick();
    check("rr_stall_ptr", 32'(rr4), 32'h2);
    b4.out_ready = 4'b1111;
    beat(2'b10, 2'd0, 8'h66, 4'b0100, 1'b1);
    tick();
    check("rr_resume_ptr", 32'(rr4), 32'h3);
    check("rr_resume_data", 32'(b4.dout[23:16]), 32'h66);
    b4.in_valid = 1'b0;
    tick();

    // reset with channels 1 and 3 full and rr_ptr at 2
    b4.out_ready = 4'b0101;
    beat(2'b10, 2'd0, 8'h88, 4'b1000, 1'b1);
    tick();
    beat(2'b10, 2'd0, 8'hAA, 4'b0001, 1'b1);
    tick();
    beat(2'b10, 2'd0, 8'hBB, 4'b0010, 1'b1);
    tick();
    b4.in_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(b4.out_valid), 32'hA);
    check("pre_rst_rr", 32'(rr4), 32'h2);
    check("pre_rst_pending", 32'(sb.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(b4.out_valid), 32'h0);
    check("mid_rst_dout", b4.dout, 32'h0);
    check("mid_rst_rr", 32'(rr4), 32'h0);
    check("mid_rst_err", 32'(err4), 32'h0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    b4.out_ready = 4'b1111;
    tick();

    // out-of-range select on the 3-channel instance, plain and reserved mode
    b3.mode = 2'b00; b3.sel = 2'd3; b3.din = 8'h5A; b3.in_valid = 1'b1;
    #1;
    check("oor_in_ready", 32'(b3.in_ready), 32'h1);
    check("oor_err_before", 32'(err3), 32'h0);
    tick();
    b3.in_valid = 1'b0;
    check("oor_err_pulse", 32'(err3), 32'h1);
    check("oor_no_valid", 32'(b3.out_valid), 32'h0);
    tick();
    check("oor_err_clear", 32'(err3), 32'h0);
    b3.mode = 2'b11; b3.sel = 2'd1; b3.din = 8'hC3; b3.in_valid = 1'b1;
    #1;
    check("rsv_in_ready", 32'(b3.in_ready), 32'h1);
    tick();
    check("rsv_valid", 32'(b3.out_valid), 32'h2);
    check("rsv_dout", 32'(b3.dout[15:8]), 32'hC3);
    check("rsv_no_err", 32'(err3), 32'h0);
    b3.sel = 2'd3;
    tick();
    b3.in_valid = 1'b0;
    check("rsv_oor_err", 32'(err3), 32'h1);
    tick();
    check("rsv_oor_clear", 32'(err3), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_1ton.md
# demux_stream_1ton

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking on the input and on every output channel. It is the next generation of the team's combinational 1-to-4 demux. It adds:
- configurable data width and channel count;
- one-entry output buffering per channel with backpressure;
- addressed, broadcast and round-robin steering modes;
- an error pulse for out-of-range selects.

It sits between a single producer stream and N independent consumers.

## Interface
- `DATA_W`, default 8: data width in bits per beat, ≥1.
- `N_CH`, default 4: number of output channels, 2..16.
- `SEL_W`, default `$clog2(N_CH)`: select width. Derived; not overridden.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `mode`  in  2: steering mode. 00 addressed, 01 broadcast, 10 round-robin, 11 reserved (treated as addressed).
- `din`  in  DATA_W: input data.
- `sel`  in  SEL_W: target channel in addressed mode; ignored otherwise.
- `in_valid`  in  1: input beat present.
- `in_ready`  out  1: block accepts the beat this cycle.
- `dout`  out  N_CH*DATA_W: channel i data on bits [i*DATA_W +: DATA_W].
- `out_valid`  out  N_CH: per-channel beat present.
- `out_ready`  in  N_CH: per-channel consumer ready.
- `err`  out  1: one-cycle pulse when an addressed beat with `sel` ≥ N_CH is consumed and dropped.
- `rr_ptr`  out  SEL_W: current round-robin target, for debug and verification.

## Operation
- Each channel i has a one-entry register holding `data_q[i]` and `out_valid[i]`.
- Channel i can take a beat when `!out_valid[i] || out_ready[i]` (pass-through drain, no bubble).
- Target set for the current beat:
  - addressed: {`sel`};
  - broadcast: all channels;
  - round-robin: {`rr_ptr`}.
- `in_ready`:
  - 1 when every channel in the target set can take a beat;
  - 1 unconditionally for an addressed beat with `sel` ≥ N_CH. Such a beat is consumed, dropped, and pulses `err` in the next cycle.
- A beat is accepted when `in_valid && in_ready`. On acceptance, each target channel loads `din` and sets `out_valid`.
- A channel whose beat drains (`out_valid && out_ready`) and that is not reloaded clears `out_valid`.
- Round-robin pointer:
  - advances by 1 on each accepted round-robin beat, wrapping N_CH-1 → 0;
  - holds in other modes and on stalled beats.
- `mode` is sampled per beat; a change takes effect on the next acceptance decision with no flush.
- Input must hold `din`, `sel`, `mode` stable while `in_valid && !in_ready`. This is a producer obligation; the block does not check it.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied externally): `out_valid`=0, `dout`=0, `err`=0, `rr_ptr`=0. `in_ready` follows from the empty buffers.
- Latency: a beat accepted in cycle t is visible on `dout`/`out_valid` in cycle t+1.
- Throughput: 1 beat/cycle when target consumers hold `out_ready`=1.
- `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `rr_ptr`. It does not depend on `in_valid`.
- Simultaneous drain and load on the same channel: the new data is loaded and `out_valid` stays 1.
- Broadcast with one channel stalled: `in_ready`=0. No partial writes; all channels load in the same cycle.
- Reset mid-transfer: buffered beats are discarded, with no output glitch other than the asynchronous clear.
- `err` is registered: high exactly one cycle, at t+1.

## Structure
- Package `demux_pkg`:
  - localparams `MODE_ADDR`=2'b00, `MODE_BCAST`=2'b01, `MODE_RR`=2'b10;
  - a function returning the target one-hot vector from `mode`, `sel` and `rr_ptr`.
- Sub-module `demux_chan_reg`: the one-entry buffer for a single channel (load, drain, valid), instantiated N_CH times via generate.
- Top level holds target decode, `in_ready`, the round-robin pointer and `err`.

## Test plan
- Addressed sweep, N_CH=4, all `out_ready`=1, `din`=8'hA5, `sel`=0..3 in consecutive cycles → `out_valid` one-hot 0001, 0010, 0100, 1000 one cycle later; each `dout` slice = A5.
- Backpressure: addressed `sel`=2, `out_ready[2]`=0, two beats 11 then 22 → first beat held in channel 2, `in_ready`=0 on the second; raising `out_ready[2]` drains 11 and loads 22 in the same cycle.
- Broadcast: `din`=8'h3C, `out_ready`=1011 with channel 2 holding a beat → `in_ready`=0. Once channel 2 drains, all four channels show 3C and `out_valid`=1111 next cycle.
- Round-robin: 6 beats 01..06, all ready → channels 0,1,2,3,0,1 receive them; `rr_ptr`=2 afterwards. A stalled beat must not advance `rr_ptr`.
- Out-of-range select: N_CH=3, `sel`=3, `in_valid`=1 → `in_ready`=1, no `out_valid` change, `err`=1 for exactly one cycle.
- Reset mid-operation: assert `rst_n`=0 with channels 1 and 3 full and `rr_ptr`=2 → immediately `out_valid`=0000, `dout`=0, `rr_ptr`=0, `err`=0.
